// File: rtl/ooo_pkg.sv
// Shared out-of-order core definitions: default widths and the CDB broadcast
// record used by the CDB arbiter, the issuer and the ROB.
package ooo_pkg;

    localparam int FU_COUNT_DFLT = 8;
    localparam int DATA_W_DFLT   = 8;
    localparam int TAG_W_DFLT    = 4;
    localparam int ROB_W_DFLT    = 8;

    typedef struct packed {
        logic                     valid;
        logic [TAG_W_DFLT-1:0]    tag;
        logic [DATA_W_DFLT-1:0]   val;
        logic [ROB_W_DFLT-1:0]    robid;
    } cdb_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found when
// searching upward from ptr, wrapping at N.
module rr_arbiter #(
    parameter  int N     = 8,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    always_comb begin
        logic [IDX_W-1:0] w_idx;
        grant     = '0;
        grant_idx = '0;
        w_idx     = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = IDX_W'((int'(ptr) + k) % N);
            if (grant == '0 && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                grant_idx    = w_idx;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per functional unit, drained onto
// the CDB one result per cycle in round-robin order.
module cdb_arbiter
    import ooo_pkg::*;
#(
    parameter int FU_COUNT = FU_COUNT_DFLT,
    parameter int DATA_W   = DATA_W_DFLT,
    parameter int TAG_W    = TAG_W_DFLT,
    parameter int ROB_W    = ROB_W_DFLT
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic [FU_COUNT-1:0]              fu_valid,
    input  logic [FU_COUNT-1:0][DATA_W-1:0]  fu_val,
    input  logic [FU_COUNT-1:0][TAG_W-1:0]   fu_tag,
    input  logic [FU_COUNT-1:0][ROB_W-1:0]   fu_robid,
    output logic [FU_COUNT-1:0]              fus_busy,
    output logic                             cdbtransmit,
    output logic [TAG_W-1:0]                 cdbid,
    output logic [DATA_W-1:0]                cdbval,
    output logic [ROB_W-1:0]                 cdbrobid,
    output logic                             overflow
);

    localparam int RR_W = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;

    logic [FU_COUNT-1:0]             r_holdValid;
    logic [FU_COUNT-1:0][DATA_W-1:0] r_holdVal;
    logic [FU_COUNT-1:0][TAG_W-1:0]  r_holdTag;
    logic [FU_COUNT-1:0][ROB_W-1:0]  r_holdRob;
    logic [RR_W-1:0]                 r_rr;
    logic                            r_cdbTransmit;
    logic [TAG_W-1:0]                r_cdbId;
    logic [DATA_W-1:0]               r_cdbVal;
    logic [ROB_W-1:0]                r_cdbRob;
    logic                            r_overflow;

    logic [FU_COUNT-1:0]             w_grantRaw;
    logic [FU_COUNT-1:0]             w_grant;
    logic [FU_COUNT-1:0]             w_busy;
    logic [FU_COUNT-1:0]             w_capture;
    logic [FU_COUNT-1:0]             w_violation;
    logic [RR_W-1:0]                 w_grantIdx;
    logic                            w_anyGrant;

    rr_arbiter #(.N(FU_COUNT)) u_rrArbiter (
        .req       (r_holdValid),
        .ptr       (r_rr),
        .grant     (w_grantRaw),
        .grant_idx (w_grantIdx)
    );

    // A slot granted this cycle is free to accept a new result on the same edge.
    always_comb begin
        w_grant     = flush ? '0 : w_grantRaw;
        w_anyGrant  = |w_grant;
        w_busy      = r_holdValid & ~w_grant;
        w_capture   = fu_valid & ~w_busy & {FU_COUNT{~flush}};
        w_violation = fu_valid & w_busy;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_holdValid <= '0;
            r_holdVal   <= '0;
            r_holdTag   <= '0;
            r_holdRob   <= '0;
        end else begin
            for (int i = 0; i < FU_COUNT; i++) begin
                if (flush) begin
                    r_holdValid[i] <= 1'b0;
                end else if (w_capture[i]) begin
                    r_holdValid[i] <= 1'b1;
                    r_holdVal[i]   <= fu_val[i];
                    r_holdTag[i]   <= fu_tag[i];
                    r_holdRob[i]   <= fu_robid[i];
                end else if (w_grant[i]) begin
                    r_holdValid[i] <= 1'b0;
                end
            end
        end
    end

    // Data fields keep their last broadcast when the bus goes idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cdbTransmit <= 1'b0;
            r_cdbId       <= '0;
            r_cdbVal      <= '0;
            r_cdbRob      <= '0;
            r_rr          <= '0;
        end else begin
            r_cdbTransmit <= w_anyGrant;
            if (w_anyGrant) begin
                r_cdbId  <= r_holdTag[w_grantIdx];
                r_cdbVal <= r_holdVal[w_grantIdx];
                r_cdbRob <= r_holdRob[w_grantIdx];
                r_rr     <= (w_grantIdx == RR_W'(FU_COUNT - 1)) ? '0 : w_grantIdx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (|w_violation) begin
            r_overflow <= 1'b1;
        end
    end

    assign fus_busy    = w_busy;
    assign cdbtransmit = r_cdbTransmit;
    assign cdbid       = r_cdbId;
    assign cdbval      = r_cdbVal;
    assign cdbrobid    = r_cdbRob;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios then random traffic,
// all compared against a slot-level behavioural model kept here.
module tb_cdb_arbiter;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic [7:0]      fuValid;
    logic [7:0][7:0] fuVal;
    logic [7:0][3:0] fuTag;
    logic [7:0][7:0] fuRob;
    logic [7:0]      fusBusy;
    logic            cdbtransmit;
    logic [3:0]      cdbid;
    logic [7:0]      cdbval;
    logic [7:0]      cdbrobid;
    logic            overflow;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model: pending results per FU, the search start point, the
    // last broadcast and the sticky error flag.
    logic [7:0] mHold;
    logic [7:0] mVal [8];
    logic [3:0] mTag [8];
    logic [7:0] mRob [8];
    int         mRr;
    logic       mT;
    logic [3:0] mId;
    logic [7:0] mV;
    logic [7:0] mR;
    logic       mOvf;

    cdb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .fu_valid    (fuValid),
        .fu_val      (fuVal),
        .fu_tag      (fuTag),
        .fu_robid    (fuRob),
        .fus_busy    (fusBusy),
        .cdbtransmit (cdbtransmit),
        .cdbid       (cdbid),
        .cdbval      (cdbval),
        .cdbrobid    (cdbrobid),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int modelGrant(input logic fl);
        int g = -1;
        if (!fl) begin
            for (int k = 0; k < 8; k++) begin
                if (g < 0 && mHold[(mRr + k) % 8]) g = (mRr + k) % 8;
            end
        end
        return g;
    endfunction

    function automatic logic [7:0] modelBusy(input logic fl);
        logic [7:0] b = mHold;
        int g = modelGrant(fl);
        if (g >= 0) b[g] = 1'b0;
        return b;
    endfunction

    task automatic modelReset();
        mHold = '0;
        mRr   = 0;
        mT    = 1'b0;
        mId   = '0;
        mV    = '0;
        mR    = '0;
        mOvf  = 1'b0;
    endtask

    task automatic modelEdge(input logic [7:0] v, input logic fl);
        int g = modelGrant(fl);
        logic [7:0] b = modelBusy(fl);
        if ((v & b) != 0) mOvf = 1'b1;
        if (fl) begin
            mHold = '0;
            mT    = 1'b0;
        end else begin
            if (g >= 0) begin
                mT       = 1'b1;
                mId      = mTag[g];
                mV       = mVal[g];
                mR       = mRob[g];
                mHold[g] = 1'b0;
                mRr      = (g + 1) % 8;
            end else begin
                mT = 1'b0;
            end
            for (int i = 0; i < 8; i++) begin
                if (v[i] && !b[i]) begin
                    mHold[i] = 1'b1;
                    mVal[i]  = fuVal[i];
                    mTag[i]  = fuTag[i];
                    mRob[i]  = fuRob[i];
                end
            end
        end
    endtask

    function automatic logic [31:0] cdbWord();
        return {11'd0, cdbtransmit, cdbid, cdbval, cdbrobid};
    endfunction

    // One clock cycle: drive at the falling edge, check busy, step the model at
    // the rising edge, check registered outputs at the next falling edge.
    task automatic applyStimulus(input logic [7:0] v, input logic fl);
        logic [7:0] expBusy;
        fuValid = v;
        flush   = fl;
        expBusy = modelBusy(fl);
        #1;
        checkOutput("fus_busy", 32'(fusBusy), 32'(expBusy));
        @(posedge clk);
        modelEdge(v, fl);
        @(negedge clk);
        fuValid = '0;
        flush   = 1'b0;
        checkOutput("cdb", cdbWord(), {11'd0, mT, mId, mV, mR});
        checkOutput("overflow", 32'(overflow), 32'(mOvf));
    endtask

    // Reset is applied between edges so its asynchronous effect is visible.
    task automatic doReset();
        rst = 1'b0;
        #1;
        checkOutput("reset_cdb", cdbWord(), 32'd0);
        checkOutput("reset_busy", 32'(fusBusy), 32'd0);
        checkOutput("reset_ovf", 32'(overflow), 32'd0);
        modelReset();
        #2 rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] v;
        logic       fl;
        rst     = 1'b0;
        flush   = 1'b0;
        fuValid = '0;
        fuVal   = '0;
        fuTag   = '0;
        fuRob   = '0;
        modelReset();
        @(negedge clk);

        doReset();
        fuTag[3] = 4'h5;
        fuVal[3] = 8'hAA;
        fuRob[3] = 8'h07;
        applyStimulus(8'h08, 1'b0);
        checkOutput("single_latency", 32'(cdbtransmit), 32'd0);
        applyStimulus(8'h00, 1'b0);
        checkOutput("single_cdb", cdbWord(), {11'd0, 1'b1, 4'h5, 8'hAA, 8'h07});
        applyStimulus(8'h00, 1'b0);
        checkOutput("single_once", 32'(cdbtransmit), 32'd0);

        doReset();
        fuTag[0] = 4'h1; fuVal[0] = 8'h01; fuRob[0] = 8'h10;
        fuTag[2] = 4'h2; fuVal[2] = 8'h02; fuRob[2] = 8'h20;
        fuTag[5] = 4'h5; fuVal[5] = 8'h05; fuRob[5] = 8'h50;
        applyStimulus(8'h25, 1'b0);
        applyStimulus(8'h00, 1'b0);
        checkOutput("rr_first", 32'(cdbid), 32'h1);
        applyStimulus(8'h00, 1'b0);
        checkOutput("rr_second", 32'(cdbid), 32'h2);
        applyStimulus(8'h00, 1'b0);
        checkOutput("rr_third", 32'(cdbid), 32'h5);
        fuTag[0] = 4'hA;
        fuTag[5] = 4'hB;
        applyStimulus(8'h21, 1'b0);
        applyStimulus(8'h00, 1'b0);
        checkOutput("rr_wrap_first", 32'(cdbid), 32'hA);
        applyStimulus(8'h00, 1'b0);
        checkOutput("rr_wrap_second", 32'(cdbid), 32'hB);

        doReset();
        fuTag[1] = 4'h3;
        fuRob[1] = 8'h33;
        for (int k = 0; k < 6; k++) begin
            fuVal[1] = 8'h10 + 8'(k);
            applyStimulus(8'h02, 1'b0);
            if (k >= 1) checkOutput("refill_val", {23'd0, cdbtransmit, cdbval}, {23'd0, 1'b1, 8'h0F + 8'(k)});
        end
        applyStimulus(8'h00, 1'b0);
        checkOutput("refill_last", {23'd0, cdbtransmit, cdbval}, {23'd0, 1'b1, 8'h15});

        doReset();
        for (int k = 0; k < 6; k++) begin
            fuVal[0] = 8'h40 + 8'(k);
            fuVal[1] = 8'h80 + 8'(k);
            applyStimulus(8'h03, 1'b0);
            if (k == 0) checkOutput("ovf_clear", 32'(overflow), 32'd0);
        end
        for (int k = 0; k < 3; k++) applyStimulus(8'h00, 1'b0);
        checkOutput("ovf_sticky", 32'(overflow), 32'd1);

        doReset();
        fuTag[2] = 4'h2; fuTag[4] = 4'h4; fuTag[6] = 4'h6;
        fuVal[4] = 8'h44; fuRob[4] = 8'h04;
        applyStimulus(8'h54, 1'b0);
        applyStimulus(8'h00, 1'b1);
        checkOutput("flush_busy", 32'(fusBusy), 32'd0);
        checkOutput("flush_cdb", 32'(cdbtransmit), 32'd0);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b0);
        fuVal[4] = 8'h77;
        applyStimulus(8'h10, 1'b0);
        applyStimulus(8'h00, 1'b0);
        checkOutput("flush_after", cdbWord(), {11'd0, 1'b1, 4'h4, 8'h77, 8'h04});

        doReset();
        applyStimulus(8'h04, 1'b0);
        applyStimulus(8'h4A, 1'b0);
        checkOutput("midreset_pre", 32'(cdbtransmit), 32'd1);
        #2;
        doReset();
        for (int k = 0; k < 4; k++) applyStimulus(8'h00, 1'b0);

        doReset();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 8; i++) begin
                fuVal[i] = 8'($urandom);
                fuTag[i] = 4'($urandom);
                fuRob[i] = 8'($urandom);
            end
            v  = 8'($urandom);
            fl = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 15) != 0) v = v & ~modelBusy(fl);
            applyStimulus(v, fl);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
